// File: rtl/term_loopback_pkg.sv
// Shared definitions for the terminal-tile loopback switch: per-channel mode
// encodings and the helper that places each wire group in the channel index space.
package term_loopback_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_REG    = 2'b01;
  localparam logic [1:0] MODE_TIE0   = 2'b10;
  localparam logic [1:0] MODE_TIE1   = 2'b11;

  typedef logic [1:0] mode_t;

  // Wire groups in channel order: singles, doubles (mid), doubles (end), quads.
  typedef enum logic [1:0] {
    GRP_S1    = 2'd0,
    GRP_S2MID = 2'd1,
    GRP_S2END = 2'd2,
    GRP_S4    = 2'd3
  } grp_e;

  // First channel index occupied by a group.
  function automatic int group_base(input int single_w, input int double_w,
                                    input grp_e grp);
    case (grp)
      GRP_S1:    return 0;
      GRP_S2MID: return single_w;
      GRP_S2END: return single_w + double_w;
      default:   return single_w + 2 * double_w;
    endcase
  endfunction

endpackage

// File: rtl/term_loopback_switch_lane.sv
// One loopback channel: data flop plus the output mux selected by the 2-bit mode.
// hold_zero is asserted while the configuration chain is shifting; it clears the
// flop and forces the output low so partially loaded modes never reach the fabric.
module term_loopback_lane
  import term_loopback_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  mode_t mode,
  input  logic  hold_zero,
  input  logic  din,
  output logic  dout
);

  logic data_q;

  // Data flop samples every cycle regardless of mode, so a channel switched to
  // registered mode never shows stale data from before the load.
  // NOTE: flops use non-blocking (<=) so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         data_q <= 1'b0;
    else if (hold_zero) data_q <= 1'b0;
    else                data_q <= din;
  end

  // Output mux: direct path, flopped path or a constant tie.
  // NOTE: dout gets a default first so no branch can leave it unassigned (no latch).
  always_comb begin
    dout = 1'b0;
    if (!hold_zero) begin
      case (mode)
        MODE_DIRECT: dout = din;
        MODE_REG:    dout = data_q;
        MODE_TIE0:   dout = 1'b0;
        MODE_TIE1:   dout = 1'b1;
        default:     dout = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/term_loopback_switch.sv
// Terminal-tile loopback switch: south-bound wires return north-bound in
// index-reversed order, each channel with a serially loaded 2-bit mode
// (direct / registered / tie-0 / tie-1).
// Optional feature macro: TERM_LOOPBACK_SHADOW_EN -- adds an active mode register
// loaded from the chain one cycle after ConfigEn falls, so outputs keep running
// on the old modes while a new configuration is shifted in.
module term_loopback_switch
  import term_loopback_pkg::*;
#(
  parameter int SINGLE_W = 4,
  parameter int DOUBLE_W = 8,
  parameter int QUAD_W   = 16
) (
  input  logic                UserCLK,
  input  logic                resetn,
  input  logic                ConfigIn,
  input  logic                ConfigEn,
  output logic                ConfigOut,
  input  logic [SINGLE_W-1:0] S1END,
  input  logic [DOUBLE_W-1:0] S2MID,
  input  logic [DOUBLE_W-1:0] S2END,
  input  logic [QUAD_W-1:0]   S4END,
  output logic [SINGLE_W-1:0] N1BEG,
  output logic [DOUBLE_W-1:0] N2BEG,
  output logic [DOUBLE_W-1:0] N2BEGb,
  output logic [QUAD_W-1:0]   N4BEG
);

  localparam int NCH   = SINGLE_W + 2 * DOUBLE_W + QUAD_W;
  localparam int CFG_W = 2 * NCH;

  localparam int BASE_S1    = group_base(SINGLE_W, DOUBLE_W, GRP_S1);
  localparam int BASE_S2MID = group_base(SINGLE_W, DOUBLE_W, GRP_S2MID);
  localparam int BASE_S2END = group_base(SINGLE_W, DOUBLE_W, GRP_S2END);
  localparam int BASE_S4    = group_base(SINGLE_W, DOUBLE_W, GRP_S4);

  // Zero-width groups would collapse the port vectors; refuse them at elaboration.
  if (SINGLE_W < 1 || DOUBLE_W < 1 || QUAD_W < 1) begin : g_bad_width
    $error("term_loopback_switch: SINGLE_W, DOUBLE_W and QUAD_W must all be >= 1");
  end

  logic [CFG_W-1:0] cfg_q;
  logic [CFG_W-1:0] modes;
  logic             hold_zero;
  logic [NCH-1:0]   lane_in;
  logic [NCH-1:0]   lane_out;

  // Serial configuration chain: shifts toward the MSB while enabled, holds otherwise.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn)       cfg_q <= '0;
    else if (ConfigEn) cfg_q <= {cfg_q[CFG_W-2:0], ConfigIn};
  end

  assign ConfigOut = cfg_q[CFG_W-1];

`ifdef TERM_LOOPBACK_SHADOW_EN
  logic [CFG_W-1:0] act_q;
  logic             cfg_en_q;

  // Active mode register: takes the chain contents on the first edge after a load ends.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      act_q    <= '0;
      cfg_en_q <= 1'b0;
    end else begin
      cfg_en_q <= ConfigEn;
      if (!ConfigEn && cfg_en_q) act_q <= cfg_q;
    end
  end

  assign modes     = act_q;
  assign hold_zero = 1'b0;
`else
  assign modes     = cfg_q;
  assign hold_zero = ConfigEn;
`endif

  // Reversal wiring: output bit i of a group is fed from input bit W-1-i.
  for (genvar i = 0; i < SINGLE_W; i++) begin : g_s1
    assign lane_in[BASE_S1 + i] = S1END[SINGLE_W-1-i];
    assign N1BEG[i]             = lane_out[BASE_S1 + i];
  end

  for (genvar i = 0; i < DOUBLE_W; i++) begin : g_s2
    assign lane_in[BASE_S2MID + i] = S2MID[DOUBLE_W-1-i];
    assign N2BEG[i]                = lane_out[BASE_S2MID + i];
    assign lane_in[BASE_S2END + i] = S2END[DOUBLE_W-1-i];
    assign N2BEGb[i]               = lane_out[BASE_S2END + i];
  end

  for (genvar i = 0; i < QUAD_W; i++) begin : g_s4
    assign lane_in[BASE_S4 + i] = S4END[QUAD_W-1-i];
    assign N4BEG[i]             = lane_out[BASE_S4 + i];
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    term_loopback_lane u_lane (
      .clk       (UserCLK),
      .rst_n     (resetn),
      .mode      (modes[2*c +: 2]),
      .hold_zero (hold_zero),
      .din       (lane_in[c]),
      .dout      (lane_out[c])
    );
  end

endmodule

// File: tb/tb_term_loopback_switch.sv
// Scoreboard bench for term_loopback_switch: a default-size instance and a
// {1,1,1} instance share the clock, reset and configuration inputs. Stimulus
// pushes hand-computed expectations; a negedge monitor pops and compares them.
module tb_term_loopback_switch;

  logic        UserCLK = 1'b0;
  logic        resetn;
  logic        ConfigIn;
  logic        ConfigEn;
  logic        ConfigOut;
  logic [3:0]  S1END;
  logic [7:0]  S2MID, S2END;
  logic [15:0] S4END;
  logic [3:0]  N1BEG;
  logic [7:0]  N2BEG, N2BEGb;
  logic [15:0] N4BEG;

  logic s_s1, s_s2m, s_s2e, s_s4;
  logic s_n1, s_n2, s_n2b, s_n4, s_cfg_out;

  always #5 UserCLK = ~UserCLK;

  term_loopback_switch dut (
    .UserCLK  (UserCLK),
    .resetn   (resetn),
    .ConfigIn (ConfigIn),
    .ConfigEn (ConfigEn),
    .ConfigOut(ConfigOut),
    .S1END    (S1END),
    .S2MID    (S2MID),
    .S2END    (S2END),
    .S4END    (S4END),
    .N1BEG    (N1BEG),
    .N2BEG    (N2BEG),
    .N2BEGb   (N2BEGb),
    .N4BEG    (N4BEG)
  );

  term_loopback_switch #(.SINGLE_W(1), .DOUBLE_W(1), .QUAD_W(1)) dut_small (
    .UserCLK  (UserCLK),
    .resetn   (resetn),
    .ConfigIn (ConfigIn),
    .ConfigEn (ConfigEn),
    .ConfigOut(s_cfg_out),
    .S1END    (s_s1),
    .S2MID    (s_s2m),
    .S2END    (s_s2e),
    .S4END    (s_s4),
    .N1BEG    (s_n1),
    .N2BEG    (s_n2),
    .N2BEGb   (s_n2b),
    .N4BEG    (s_n4)
  );

  // Expected response; sm packs the small instance as {N4,N2b,N2,N1}.
  typedef struct {
    string       name;
    bit          chk_data;
    logic [3:0]  n1;
    logic [7:0]  n2;
    logic [7:0]  n2b;
    logic [15:0] n4;
    logic [3:0]  sm;
    logic        co;
    logic        cos;
  } exp_t;

  exp_t sb[$];
  logic hist[$];   // every bit shifted into the chains since the last reset
  int   vectors     = 0;
  int   miscompares = 0;

  // Chain output after n shifts is the bit shifted in w shifts ago, zero before that.
  function automatic logic exp_co(input int w);
    if (hist.size() >= w) return hist[hist.size() - w];
    return 1'b0;
  endfunction

  function automatic exp_t mk(input string nm, input bit chk, input logic [3:0] n1,
                              input logic [7:0] n2, input logic [7:0] n2b,
                              input logic [15:0] n4, input logic [3:0] sm);
    exp_t e;
    e.name = nm; e.chk_data = chk; e.n1 = n1; e.n2 = n2; e.n2b = n2b;
    e.n4 = n4; e.sm = sm; e.co = 1'b0; e.cos = 1'b0;
    return e;
  endfunction

  task automatic push_exp(input exp_t e);
    exp_t x;
    x     = e;
    x.co  = exp_co(72);
    x.cos = exp_co(8);
    sb.push_back(x);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: one expectation compared per falling edge.
  always @(negedge UserCLK) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.name, ".ConfigOut"},       16'(ConfigOut), 16'(e.co));
      check({e.name, ".small.ConfigOut"}, 16'(s_cfg_out), 16'(e.cos));
      if (e.chk_data) begin
        check({e.name, ".N1BEG"},  16'(N1BEG),  16'(e.n1));
        check({e.name, ".N2BEG"},  16'(N2BEG),  16'(e.n2));
        check({e.name, ".N2BEGb"}, 16'(N2BEGb), 16'(e.n2b));
        check({e.name, ".N4BEG"},  N4BEG,       e.n4);
        check({e.name, ".small.N"}, 16'({s_n4, s_n2b, s_n2, s_n1}), 16'(e.sm));
      end
    end
  end

  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  // Shift v[n-1:0] MSB first. 'during' gives the outputs expected while shifting
  // with the shadow register (old modes keep running); without it they are 0.
  task automatic shift(input string nm, input logic [71:0] v, input int n,
                       input exp_t during, input bit drop);
    exp_t e;
    for (int j = n - 1; j >= 0; j--) begin
      ConfigIn = v[j];
      ConfigEn = 1'b1;
      @(posedge UserCLK);
      #1;
      hist.push_back(v[j]);
      e      = during;
      e.name = nm;
      if (j == 0 && drop) ConfigEn = 1'b0;
`ifndef TERM_LOOPBACK_SHADOW_EN
      e.n1 = '0; e.n2 = '0; e.n2b = '0; e.n4 = '0; e.sm = '0;
      e.chk_data = !(j == 0 && drop);
`endif
      push_exp(e);
    end
    ConfigIn = 1'b0;
    if (drop) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; ConfigEn = 1'b0; ConfigIn = 1'b0;
    S1END = 4'b0001; S2MID = 8'h12; S2END = 8'h03; S4END = 16'h8001;
    s_s1 = 1'b1; s_s2m = 1'b0; s_s2e = 1'b1; s_s4 = 1'b0;
    step();
    // Direct reversal while reset is held.
    push_exp(mk("rst_rev", 1, 4'b1000, 8'h48, 8'hC0, 16'h8001, 4'b0101));
    step();

    resetn = 1'b1;
    S1END = 4'b0011; S2MID = 8'hA0; S2END = 8'h80; S4END = 16'h1234;
    s_s1 = 1'b0; s_s2m = 1'b1; s_s2e = 1'b0; s_s4 = 1'b1;
    push_exp(mk("run_rev", 1, 4'b1100, 8'h05, 8'h01, 16'h2C48, 4'b1010));
    step();

    // Channel 0 registered, all others direct (small instance: its S1 channel).
    shift("load_reg", 72'h1, 72,
          mk("", 1, 4'b1100, 8'h05, 8'h01, 16'h2C48, 4'b1010), 1'b1);
    S1END = 4'b0100; s_s1 = 1'b1;
    push_exp(mk("reg_hold", 1, 4'b0010, 8'h05, 8'h01, 16'h2C48, 4'b1010));
    step();
    S1END = 4'b1100;
    push_exp(mk("reg_pre", 1, 4'b0010, 8'h05, 8'h01, 16'h2C48, 4'b1011));
    step();
    S1END = 4'b0000; s_s1 = 1'b0;
    push_exp(mk("reg_post", 1, 4'b0001, 8'h05, 8'h01, 16'h2C48, 4'b1011));
    step();
    push_exp(mk("reg_clr", 1, 4'b0000, 8'h05, 8'h01, 16'h2C48, 4'b1010));
    step();

    // All channels tie-0.
    shift("load_tie0", {36{2'b10}}, 72,
          mk("", 1, 4'b0000, 8'h05, 8'h01, 16'h2C48, 4'b1010), 1'b1);
    S1END = 4'hF; S2MID = 8'hFF; S2END = 8'h5A; S4END = 16'hFFFF;
    s_s1 = 1'b1; s_s2m = 1'b1; s_s2e = 1'b1; s_s4 = 1'b1;
    push_exp(mk("tie0", 1, 4'h0, 8'h00, 8'h00, 16'h0000, 4'h0));
    step();

    // All channels tie-1; ConfigOut replays the tie-0 stream.
    shift("load_tie1", {72{1'b1}}, 72, mk("", 1, 4'h0, 8'h00, 8'h00, 16'h0000, 4'h0), 1'b1);
    S1END = 4'h0; S2MID = 8'h00; S2END = 8'h00; S4END = 16'h0000;
    s_s1 = 1'b0; s_s2m = 1'b0; s_s2e = 1'b0; s_s4 = 1'b0;
    push_exp(mk("tie1", 1, 4'hF, 8'hFF, 8'hFF, 16'hFFFF, 4'hF));
    step();

    // Reset in the middle of a load.
    S1END = 4'b0010; S2MID = 8'h0F; S2END = 8'h01; S4END = 16'h000F;
    s_s1 = 1'b1; s_s2m = 1'b1; s_s2e = 1'b0; s_s4 = 1'b0;
    shift("abort_shift", 72'h0, 10, mk("", 1, 4'hF, 8'hFF, 8'hFF, 16'hFFFF, 4'hF), 1'b0);
    @(negedge UserCLK);
    #1;
    resetn = 1'b0; ConfigEn = 1'b0;
    hist.delete();
    push_exp(mk("abort", 1, 4'b0100, 8'hF0, 8'h80, 16'hF000, 4'b0011));
    step();
    step();
    resetn = 1'b1;

    // Shift the cleared chain out with S2MID high; outputs are held at 0
    // (shadow build: old direct modes keep running).
    S2MID = 8'hFF;
    shift("shift_out", {72{1'b1}}, 72,
          mk("", 1, 4'b0100, 8'hFF, 8'h80, 16'hF000, 4'b0011), 1'b1);
    push_exp(mk("tie1_final", 1, 4'hF, 8'hFF, 8'hFF, 16'hFFFF, 4'hF));
    step();

    step();
    step();
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations pending, want 0", sb.size());
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
